// File: rtl/imm_ext_pkg.sv
// Shared definitions for the buffered immediate extender.
// Mode encodings and elaboration-time parameter checks.
package imm_ext_pkg;

  localparam logic [1:0] MODE_ZERO   = 2'b00;
  localparam logic [1:0] MODE_SIGN   = 2'b01;
  localparam logic [1:0] MODE_UPPER  = 2'b10;
  localparam logic [1:0] MODE_BRANCH = 2'b11;

  // Branch mode needs two spare bits above the sign-extended field.
  function automatic bit width_ok(
    input int imm_w,
    input int out_w
  );
    return out_w >= imm_w + 2;
  endfunction

  function automatic bit depth_ok(
    input int depth
  );
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: zero, sign, upper and
// branch-offset (sign-extended, word-scaled) forms.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IMM_W = 16,
  parameter int OUT_W = 32
) (
  input  logic [IMM_W-1:0] i_imm,
  input  logic [1:0]       i_mode,
  output logic [OUT_W-1:0] o_ext
);

  localparam int PAD_W = OUT_W - IMM_W;

  logic [OUT_W-1:0] w_zero;
  logic [OUT_W-1:0] w_sign;
  logic [OUT_W-1:0] w_upper;
  logic [OUT_W-1:0] w_branch;

  assign w_zero   = {{PAD_W{1'b0}}, i_imm};
  assign w_sign   = {{PAD_W{i_imm[IMM_W-1]}}, i_imm};
  assign w_upper  = {i_imm, {PAD_W{1'b0}}};
  assign w_branch = {w_sign[OUT_W-3:0], 2'b00};

  always_comb begin
    o_ext = w_zero;
    unique case (1'b1)
      (i_mode == MODE_ZERO):   o_ext = w_zero;
      (i_mode == MODE_SIGN):   o_ext = w_sign;
      (i_mode == MODE_UPPER):  o_ext = w_upper;
      (i_mode == MODE_BRANCH): o_ext = w_branch;
      default:                 o_ext = w_zero;
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Immediate extender feeding a DEPTH-entry output FIFO
// behind valid/ready handshakes on both sides.
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int IMM_W = 16,
  parameter int OUT_W = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IMM_W-1:0]       imm,
  input  logic [1:0]             mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  generate
    if (!width_ok(IMM_W, OUT_W)) begin : g_bad_width
      $error("imm_ext_pipe: OUT_W must be >= IMM_W+2");
    end
    if (!depth_ok(DEPTH)) begin : g_bad_depth
      $error("imm_ext_pipe: DEPTH must be a power of two >= 2");
    end
  endgenerate

  logic [OUT_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  logic [OUT_W-1:0] w_ext;
  logic             w_push;
  logic             w_pop;
  logic             w_full;

  imm_ext_core #(
    .IMM_W (IMM_W),
    .OUT_W (OUT_W)
  ) u_core (
    .i_imm  (imm),
    .i_mode (mode),
    .o_ext  (w_ext)
  );

  // Full blocks input even if the head leaves this cycle.
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign in_ready  = !rst && !w_full;
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_ext;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is cleared on reset, so the head reads 0 until first write.
  assign out_data = r_mem[r_rd_ptr];
  assign count    = r_count;

endmodule
